// File: rtl/rotate_arbiter_if.sv
// Request/response bundle for rotate_arbiter: two rotate requesters plus
// the downstream result channel.
interface rotate_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req0_dir;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       req1_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_src;

  // slave = the arbiter, master = requesters and consumer
  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    output req1_valid, req1_data, req1_amt, req1_dir,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src
  );
endinterface

// File: rtl/rotate_arbiter.sv
// Two requesters share one 8-bit rotate-right unit through a round-robin
// (or fixed-priority) arbiter feeding a one-entry valid/ready output register.
module barrel_shifter_8bit (
  input  logic [7:0] din,
  input  logic [2:0] amt,
  output logic [7:0] dout
);
  logic [7:0] s0, s1;

  assign s0   = amt[0] ? {din[0],   din[7:1]} : din;
  assign s1   = amt[1] ? {s0[1:0],  s0[7:2]}  : s0;
  assign dout = amt[2] ? {s1[3:0],  s1[7:4]}  : s1;
endmodule

module rotate_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  rotate_arbiter_if.slave    bus,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);
  localparam int NUM_REQ = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic                              last_q, last_d;
  logic [7:0]                        data_q, data_d;
  logic                              src_q, src_d;
  logic [NUM_REQ-1:0][COUNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0]                vld;
  logic [NUM_REQ-1:0][7:0]           rq_data;
  logic [NUM_REQ-1:0][2:0]           rq_amt;
  logic [NUM_REQ-1:0]                rq_dir;
  logic [NUM_REQ-1:0][2:0]           eff_amt;

  logic                              slot_free, accept, win;
  logic [7:0]                        rot_out;

  assign vld     = {bus.req1_valid, bus.req0_valid};
  assign rq_data = {bus.req1_data,  bus.req0_data};
  assign rq_amt  = {bus.req1_amt,   bus.req0_amt};
  assign rq_dir  = {bus.req1_dir,   bus.req0_dir};

  // Left by n is right by (8-n) mod 8, i.e. the 3-bit negation of n.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_amt
    assign eff_amt[i] = rq_dir[i] ? (3'd0 - rq_amt[i]) : rq_amt[i];
  end

  barrel_shifter_8bit u_rot (
    .din  (rq_data[win]),
    .amt  (eff_amt[win]),
    .dout (rot_out)
  );

  // Grant depends only on valids, pointer and slot state, never on payload.
  always_comb begin
    slot_free = !rst && ((state_q == EMPTY) || bus.out_ready);
    if (RR_EN) win = (&vld) ? ~last_q : vld[1];
    else       win = ~vld[0];
    accept = slot_free && (|vld);
  end

  assign bus.req0_ready = accept && !win;
  assign bus.req1_ready = accept &&  win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d      = FULL;
      data_d       = rot_out;
      src_d        = win;
      last_d       = win;
      cnt_d[win]   = cnt_q[win] + COUNT_W'(1);
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      data_q  <= 8'h00;
      src_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign cnt0          = cnt_q[0];
  assign cnt1          = cnt_q[1];
endmodule

// File: tb/tb_rotate_arbiter.sv
// Scoreboard bench for rotate_arbiter: a round-robin instance checked against
// a cycle model, plus a fixed-priority instance.
module tb_rotate_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rotate_arbiter_if bi();
  rotate_arbiter_if bf();
  logic [3:0] cnt0, cnt1, fcnt0, fcnt1;

  rotate_arbiter #(.RR_EN(1'b1), .COUNT_W(4)) u_rr (
    .clk(clk), .rst(rst), .bus(bi.slave), .cnt0(cnt0), .cnt1(cnt1));
  rotate_arbiter #(.RR_EN(1'b0), .COUNT_W(4)) u_fp (
    .clk(clk), .rst(rst), .bus(bf.slave), .cnt0(fcnt0), .cnt1(fcnt1));

  typedef struct { logic [7:0] data; logic src; } exp_t;
  exp_t q[$];
  logic       m_full, m_last;
  logic [3:0] m_cnt0, m_cnt1;
  int n_chk = 0, n_fail = 0;

  function automatic logic [7:0] exp_rot(logic [7:0] d, logic [2:0] a, logic dir);
    logic [7:0] r = d;
    for (int i = 0; i < int'(a); i++) r = dir ? {r[6:0], r[7]} : {r[0], r[7:1]};
    return r;
  endfunction

  function automatic exp_t head();
    exp_t e = '{8'h00, 1'b0};
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  function automatic logic m_win();
    if (bi.req0_valid && bi.req1_valid) return !m_last;
    return bi.req1_valid;
  endfunction

  function automatic logic m_acc();
    return (!m_full || bi.out_ready) && (bi.req0_valid || bi.req1_valid);
  endfunction

  task automatic model_reset();
    q.delete();
    m_full = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic cycle();
    logic acc = m_acc();
    logic w   = m_win();
    exp_t e;
    if (m_full && bi.out_ready && q.size() > 0) q.delete(0);
    if (acc) begin
      e.src  = w;
      e.data = w ? exp_rot(bi.req1_data, bi.req1_amt, bi.req1_dir)
                 : exp_rot(bi.req0_data, bi.req0_amt, bi.req0_dir);
      q.push_back(e);
      m_last = w;
      m_full = 1'b1;
      if (w) m_cnt1 = m_cnt1 + 4'd1; else m_cnt0 = m_cnt0 + 4'd1;
    end else if (m_full && bi.out_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [7:0] d,
                         input logic [2:0] a, input logic dir);
    if (idx == 0) begin
      bi.req0_valid = v; bi.req0_data = d; bi.req0_amt = a; bi.req0_dir = dir;
    end else begin
      bi.req1_valid = v; bi.req1_data = d; bi.req1_amt = a; bi.req1_dir = dir;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 8'hA5, 3'd1, 1'b0);
    set_req(1, 1'b1, 8'h5A, 3'd2, 1'b1);
    bi.out_ready = 1'b1;
    bf.req0_valid = 1'b0; bf.req1_valid = 1'b0; bf.out_ready = 1'b1;
    bf.req0_data = 8'h00; bf.req0_amt = 3'd0; bf.req0_dir = 1'b0;
    bf.req1_data = 8'h00; bf.req1_amt = 3'd0; bf.req1_dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bi.req0_ready !== 1'b0 || bi.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b expected 00", bi.req1_ready, bi.req0_ready); end
    n_chk++; if (bi.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bi.out_valid); end
    n_chk++; if (bi.out_data !== 8'h00 || bi.out_src !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%b expected 00/0", bi.out_data, bi.out_src); end
    n_chk++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 8'(i * 17 + 3), 3'(i), 1'(i));
      set_req(1, 1'b1, 8'(8'hF0 | i), 3'(7 - i), 1'(~i));
      #1;
      n_chk++; if (bi.req0_ready !== (m_acc() && !m_win()) || bi.req1_ready !== (m_acc() && m_win())) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b%b expected %b%b", i, bi.req1_ready, bi.req0_ready,
                           m_acc() && m_win(), m_acc() && !m_win()); end
      cycle();
      e = head();
      n_chk++; if (bi.out_src !== 1'(i % 2)) begin
        n_fail++; $display("FAIL rr_alternate[%0d]: got %b expected %b", i, bi.out_src, 1'(i % 2)); end
      n_chk++; if (bi.out_data !== e.data || bi.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_data[%0d]: got %h v=%b expected %h v=1", i, bi.out_data, bi.out_valid, e.data); end
    end
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle();
  endtask

  task automatic test_rotate();
    logic       t_src [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_dat [6] = '{8'h81, 8'h81, 8'h12, 8'h5A, 8'h5A, 8'h96};
    logic [2:0] t_amt [6] = '{3'd1, 3'd1, 3'd4, 3'd0, 3'd0, 3'd3};
    logic       t_dir [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] t_exp [6] = '{8'hC0, 8'h03, 8'h21, 8'h5A, 8'h5A, 8'hB4};
    exp_t e;
    bi.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(int'(t_src[i]), 1'b1, t_dat[i], t_amt[i], t_dir[i]);
      #1;
      n_chk++; if ((t_src[i] ? bi.req1_ready : bi.req0_ready) !== 1'b1) begin
        n_fail++; $display("FAIL rot_ready[%0d]: got 0 expected 1", i); end
      cycle();
      set_req(int'(t_src[i]), 1'b0, 8'h00, 3'd0, 1'b0);
      e = head();
      n_chk++; if (bi.out_valid !== 1'b1 || bi.out_data !== t_exp[i] || bi.out_data !== e.data) begin
        n_fail++; $display("FAIL rot_data[%0d]: got %h v=%b expected %h", i, bi.out_data, bi.out_valid, t_exp[i]); end
      n_chk++; if (bi.out_src !== t_src[i]) begin
        n_fail++; $display("FAIL rot_src[%0d]: got %b expected %b", i, bi.out_src, t_src[i]); end
      n_chk++; if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
        n_fail++; $display("FAIL rot_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1); end
    end
    cycle();
  endtask

  task automatic test_fixed_priority();
    bf.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bf.req0_valid = 1'b1; bf.req0_data = 8'(8'h81 + i); bf.req0_amt = 3'd1; bf.req0_dir = 1'b0;
      bf.req1_valid = 1'b1; bf.req1_data = 8'h3C; bf.req1_amt = 3'd2; bf.req1_dir = 1'b1;
      #1;
      n_chk++; if (bf.req0_ready !== 1'b1 || bf.req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL fp_ready[%0d]: got %b%b expected 01", i, bf.req1_ready, bf.req0_ready); end
      cycle();
      n_chk++; if (bf.out_src !== 1'b0 || bf.out_data !== exp_rot(8'(8'h81 + i), 3'd1, 1'b0)) begin
        n_fail++; $display("FAIL fp_out[%0d]: got %h/%b expected %h/0", i, bf.out_data, bf.out_src,
                           exp_rot(8'(8'h81 + i), 3'd1, 1'b0)); end
    end
    n_chk++; if (fcnt0 !== 4'd4 || fcnt1 !== 4'd0) begin
      n_fail++; $display("FAIL fp_cnt: got %0d/%0d expected 4/0", fcnt0, fcnt1); end
    bf.req0_valid = 1'b0; bf.req1_valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] held;
    bi.out_ready = 1'b1;
    set_req(1, 1'b1, 8'hC3, 3'd5, 1'b0);
    #1 cycle();
    bi.out_ready = 1'b0;
    set_req(0, 1'b1, 8'h0F, 3'd2, 1'b1);
    held = head().data;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (bi.req0_ready !== 1'b0 || bi.req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b%b expected 00", i, bi.req1_ready, bi.req0_ready); end
      cycle();
      n_chk++; if (bi.out_valid !== 1'b1 || bi.out_data !== held) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h v=%b expected %h v=1", i, bi.out_data, bi.out_valid, held); end
    end
    bi.out_ready = 1'b1;
    #1;
    n_chk++; if (bi.req0_ready !== (m_acc() && !m_win()) || bi.req1_ready !== (m_acc() && m_win())) begin
      n_fail++; $display("FAIL refill_ready: got %b%b expected %b%b", bi.req1_ready, bi.req0_ready,
                         m_acc() && m_win(), m_acc() && !m_win()); end
    cycle();
    e = head();
    n_chk++; if (bi.out_valid !== 1'b1 || bi.out_data !== e.data || bi.out_src !== e.src) begin
      n_fail++; $display("FAIL refill_out: got %h/%b v=%b expected %h/%b v=1", bi.out_data, bi.out_src,
                         bi.out_valid, e.data, e.src); end
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle();
    n_chk++; if (bi.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %b expected 0", bi.out_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bi.out_ready = 1'b1;
    set_req(0, 1'b1, 8'h3C, 3'd2, 1'b0);
    #1 cycle();
    set_req(0, 1'b1, 8'h77, 3'd1, 1'b0);
    bi.out_ready = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bi.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bi.out_valid); end
    n_chk++; if (bi.req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready: got %b expected 0", bi.req0_ready); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bi.out_ready = 1'b1;
    set_req(1, 1'b1, 8'h11, 3'd3, 1'b1);
    #1;
    n_chk++; if (bi.req0_ready !== 1'b1 || bi.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_first_grant: got %b%b expected 01", bi.req1_ready, bi.req0_ready); end
    cycle();
    e = head();
    n_chk++; if (bi.out_src !== 1'b0 || bi.out_data !== e.data) begin
      n_fail++; $display("FAIL rst_first_out: got %h/%b expected %h/0", bi.out_data, bi.out_src, e.data); end
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle();
  endtask

  task automatic test_count_wrap();
    logic [3:0] c1;
    bi.out_ready = 1'b1;
    set_req(1, 1'b1, 8'h01, 3'd1, 1'b0);
    #1 cycle();
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    c1 = m_cnt1;
    for (int i = 0; i < 20 && m_cnt0 != 4'hF; i++) begin
      set_req(0, 1'b1, 8'(i), 3'(i), 1'b0);
      #1 cycle();
    end
    n_chk++; if (cnt0 !== 4'hF || cnt1 !== c1) begin
      n_fail++; $display("FAIL cnt_full: got %0d/%0d expected 15/%0d", cnt0, cnt1, c1); end
    set_req(0, 1'b1, 8'hE7, 3'd6, 1'b1);
    #1 cycle();
    n_chk++; if (cnt0 !== 4'h0) begin
      n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", cnt0); end
    n_chk++; if (cnt1 !== c1) begin
      n_fail++; $display("FAIL cnt_other: got %0d expected %0d", cnt1, c1); end
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rotate();
    test_fixed_priority();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
